// File: rtl/fxp_mult_arbiter.sv
// fxp_mult_arbiter
//   Round-robin arbiter sharing one unsigned fixed-point multiplier between
//   NUM_REQ requesters. The winning lane's operands are multiplied and scaled
//   by 2**-FRAC_W into a single registered response slot tagged with the lane id.
//   Build option FXP_MULT_ROUND_EN: round half up instead of truncating.
//   The rounding form assumes FRAC_W >= 1.

module fxp_mult_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IN_W    = 4,
  parameter int FRAC_W  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*IN_W-1:0]    req_a,
  input  logic [NUM_REQ*IN_W-1:0]    req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [2*IN_W-1:0]          rsp_product
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int PW   = 2 * IN_W;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t            state_r;
  logic [ID_W-1:0]   rr_ptr_r;

  logic [ID_W:0]     pick_s;
  logic              grant_found_s;
  logic [ID_W-1:0]   grant_idx_s;
  logic              slot_free_s;
  logic              grant_fire_s;
  logic [IN_W-1:0]   lane_a_s;
  logic [IN_W-1:0]   lane_b_s;
  logic [PW-1:0]     product_s;
  logic [ID_W-1:0]   next_ptr_s;

  // Round-robin search from ptr upward with wrap; returns {found, index}.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [ID_W-1:0]    ptr);
    logic            found;
    logic [ID_W-1:0] idx;
    int              j;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!found && valid[j]) begin
        found = 1'b1;
        idx   = ID_W'(j);
      end else begin
        idx = idx;
      end
    end
    return {found, idx};
  endfunction

  // Full-precision product scaled back to FRAC_W fractional bits.
  function automatic logic [PW-1:0] fxp_scale(input logic [IN_W-1:0] a,
                                              input logic [IN_W-1:0] b);
    logic [PW-1:0] full;
`ifdef FXP_MULT_ROUND_EN
    logic [PW:0]   sum;
`endif
    full = PW'(a) * PW'(b);
`ifdef FXP_MULT_ROUND_EN
    // One extra bit keeps the rounding add from wrapping.
    sum = {1'b0, full} + ((PW+1)'(1) << (FRAC_W - 1));
    return PW'(sum >> FRAC_W);
`else
    return full >> FRAC_W;
`endif
  endfunction

  // Arbitration and operand mux; grant is same-cycle and ignores operand values.
  always_comb begin
    pick_s        = rr_pick(req_valid, rr_ptr_r);
    grant_found_s = pick_s[ID_W];
    grant_idx_s   = pick_s[ID_W-1:0];
    slot_free_s   = (state_r == IDLE) || rsp_ready;
    grant_fire_s  = grant_found_s && slot_free_s && !rst;
    lane_a_s      = req_a[grant_idx_s*IN_W +: IN_W];
    lane_b_s      = req_b[grant_idx_s*IN_W +: IN_W];
    product_s     = fxp_scale(lane_a_s, lane_b_s);
    if (grant_fire_s) begin
      req_ready = NUM_REQ'(1) << grant_idx_s;
    end else begin
      req_ready = '0;
    end
    if (grant_idx_s == ID_W'(NUM_REQ - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = grant_idx_s + ID_W'(1);
    end
  end

  // Response slot FSM, round-robin pointer and registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      rr_ptr_r    <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_product <= '0;
    end else begin
      if (grant_fire_s) begin
        rr_ptr_r <= next_ptr_s;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
      case (state_r)
        IDLE: begin
          if (grant_fire_s) begin
            state_r     <= FULL;
            rsp_valid   <= 1'b1;
            rsp_id      <= grant_idx_s;
            rsp_product <= product_s;
          end else begin
            state_r     <= IDLE;
            rsp_valid   <= 1'b0;
          end
        end
        FULL: begin
          if (grant_fire_s) begin
            // Downstream takes the old result while the new one loads.
            state_r     <= FULL;
            rsp_valid   <= 1'b1;
            rsp_id      <= grant_idx_s;
            rsp_product <= product_s;
          end else if (rsp_ready) begin
            state_r     <= IDLE;
            rsp_valid   <= 1'b0;
          end else begin
            state_r     <= FULL;
            rsp_valid   <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_mult_arbiter.sv
// tb_fxp_mult_arbiter
//   Directed stimulus with hand-computed results; a scoreboard queue is filled
//   on each expected grant and drained by a monitor at every response handshake.

module tb_fxp_mult_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_product;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] prod;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef FXP_MULT_ROUND_EN
  localparam logic [7:0] EXP_3X1 = 8'h01;
`else
  localparam logic [7:0] EXP_3X1 = 8'h00;
`endif

  fxp_mult_arbiter #(.NUM_REQ(4), .IN_W(4), .FRAC_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [3:0] a, input logic [3:0] b);
    req_a[i*4 +: 4] = a;
    req_b[i*4 +: 4] = b;
  endtask

  task automatic push(input logic [1:0] id, input logic [7:0] prod);
    exp_t e;
    e.id   = id;
    e.prod = prod;
    sb_q.push_back(e);
  endtask

  // Reset with all lanes requesting; ends at the negedge after reset releases.
  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("ready_in_reset", 32'(req_ready), 32'h0);
    tick();
    rst       = 1'b0;
    req_valid = 4'b0000;
    sb_q.delete();
    @(negedge clk);
    check("post_rst_valid", 32'(rsp_valid), 32'h0);
    check("post_rst_id", 32'(rsp_id), 32'h0);
    check("post_rst_prod", 32'(rsp_product), 32'h0);
  endtask

  // Let outstanding results drain within a bounded number of cycles.
  task automatic drain();
    tick();
    rsp_ready = 1'b1;
    req_valid = 4'b0000;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!rsp_valid && sb_q.size() == 0) break;
      tick();
    end
    check("drain_empty", {31'(sb_q.size()), rsp_valid}, 32'h0);
  endtask

  // Monitor: compare every response that the downstream accepts.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_id), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_product", 32'(rsp_product), 32'(e.prod));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_rdy [5];
    exp_rdy[0] = 4'b0001; exp_rdy[1] = 4'b0010; exp_rdy[2] = 4'b0100;
    exp_rdy[3] = 4'b1000; exp_rdy[4] = 4'b0001;
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0;

    // Test 1: single lane 0, 2.5 * 1.5 = 3.75
    do_reset();
    tick();
    set_lane(0, 4'b1010, 4'b0110);
    req_valid = 4'b0001;
    @(negedge clk);
    check("t1_ready", 32'(req_ready), 32'h1);
    push(2'd0, 8'h0F);
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    check("t1_latency_valid", 32'(rsp_valid), 32'h1);
    check("t1_latency_id", 32'(rsp_id), 32'h0);
    drain();

    // Test 2: all lanes held valid, one grant per cycle in rotation
    do_reset();
    tick();
    rsp_ready = 1'b1;
    set_lane(0, 4'd4, 4'd4);
    set_lane(1, 4'd8, 4'd5);
    set_lane(2, 4'd12, 4'd3);
    set_lane(3, 4'd13, 4'd4);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      logic [7:0] pv [4];
      pv[0] = 8'd4; pv[1] = 8'd10; pv[2] = 8'd9; pv[3] = 8'd13;
      @(negedge clk);
      check("t2_ready", 32'(req_ready), 32'(exp_rdy[k]));
      if (k > 0) check("t2_rsp_valid", 32'(rsp_valid), 32'h1);
      push(2'(k % 4), pv[k % 4]);
      tick();
    end
    req_valid = 4'b0000;
    drain();

    // Tests 3/4: stall holds the slot, then back-to-back grant of lane 1
    do_reset();
    tick();
    set_lane(0, 4'hF, 4'hF);
    set_lane(1, 4'h3, 4'h1);
    req_valid = 4'b0001;
    @(negedge clk);
    check("t3_ready_fill", 32'(req_ready), 32'h1);
    push(2'd0, 8'h38);
    tick();
    req_valid = 4'b0110;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_stall_ready", 32'(req_ready), 32'h0);
      check("t3_stall_valid", 32'(rsp_valid), 32'h1);
      check("t3_stall_id", 32'(rsp_id), 32'h0);
      check("t3_stall_prod", 32'(rsp_product), 32'h38);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t3_b2b_ready", 32'(req_ready), 32'h2);
    push(2'd1, EXP_3X1);
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    check("t3_b2b_id", 32'(rsp_id), 32'h1);
    drain();

    // Test 5: reset drops a pending result and rewinds the pointer
    do_reset();
    tick();
    set_lane(2, 4'd12, 4'd3);
    req_valid = 4'b0100;
    @(negedge clk);
    check("t5_ready", 32'(req_ready), 32'h4);
    push(2'd2, 8'd9);
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    check("t5_full", 32'(rsp_valid), 32'h1);
    do_reset();
    tick();
    set_lane(1, 4'd8, 4'd5);
    req_valid = 4'b1010;
    @(negedge clk);
    check("t5_ready_after_rst", 32'(req_ready), 32'h2);
    push(2'd1, 8'd10);
    drain();

    // Test 6: wrap search reaches lane 3, pointer wraps to 0
    do_reset();
    tick();
    rsp_ready = 1'b1;
    set_lane(3, 4'd13, 4'd4);
    set_lane(0, 4'd4, 4'd4);
    req_valid = 4'b1000;
    @(negedge clk);
    check("t6_ready_lane3", 32'(req_ready), 32'h8);
    push(2'd3, 8'd13);
    tick();
    req_valid = 4'b1001;
    @(negedge clk);
    check("t6_ptr_wrapped", 32'(req_ready), 32'h1);
    push(2'd0, 8'd4);
    tick();
    req_valid = 4'b0000;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
